// File: rtl/bin_to_bcd_if.sv
// Bundles the conversion request and registered result of bin_to_bcd.
// The master drives binary_in/valid_i; the slave returns bcd_o/ovf_o/valid_o.
// There is no handshake: a new value is accepted on every clock.
interface bin_to_bcd_if;
  logic [15:0] binary_in;
  logic        valid_i;
  logic [15:0] bcd_o;
  logic        ovf_o;
  logic        valid_o;

  modport master (
    output binary_in,
    output valid_i,
    input  bcd_o,
    input  ovf_o,
    input  valid_o
  );

  modport slave (
    input  binary_in,
    input  valid_i,
    output bcd_o,
    output ovf_o,
    output valid_o
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Registered 16-bit binary to 4-digit packed BCD (double dabble), with overflow and valid sideband.
// Latency: 1 clock from binary_in/valid_i to bcd_o/ovf_o/valid_o.
// Backpressure: none; a conversion is accepted and produced on every clock.
module bin_to_bcd (
  input  logic         clk_i,
  input  logic         rst_i,
  bin_to_bcd_if.slave  bus
);

  // Registered result; ovf marks values above 9999.
  typedef struct packed {
    logic        ovf;
    logic [15:0] bcd;
  } result_t;

  // Shift register: five BCD digits above the 16 binary bits still to be shifted in.
  logic [35:0] dabble_sr;
  logic [19:0] dabble_bcd;
  result_t     next_res;
  result_t     res_q;
  logic        valid_q;

  // Combinational double dabble: add 3 to every digit >= 5, then shift, 16 times.
  always_comb begin
    dabble_sr = {20'd0, bus.binary_in};
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 5; d++) begin
        if (dabble_sr[16 + 4*d +: 4] >= 4'd5) begin
          dabble_sr[16 + 4*d +: 4] = dabble_sr[16 + 4*d +: 4] + 4'd3;
        end
      end
      dabble_sr = dabble_sr << 1;
    end
    dabble_bcd = dabble_sr[35:16];
  end

  // Keep the low four digits (value mod 10000); a non-zero fifth digit means overflow.
  always_comb begin
    next_res.bcd = dabble_bcd[15:0];
    next_res.ovf = (dabble_bcd[19:16] != 4'd0);
  end

  // Output registers; reset wins over the input sampled on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= next_res;
      valid_q <= bus.valid_i;
    end
  end

  assign bus.bcd_o   = res_q.bcd;
  assign bus.ovf_o   = res_q.ovf;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and exhaustive bench for bin_to_bcd with a queue-based scoreboard.
// Expected results come from a decimal division model, independent of double dabble.
module tb_bin_to_bcd;

  logic clk_i;
  logic rst_i;

  bin_to_bcd_if bus ();

  bin_to_bcd dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic        vld;
    logic [15:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Reference: value mod 10000 split into decimal digits.
  function automatic logic [15:0] ref_bcd(input logic [15:0] val);
    int m;
    logic [15:0] r;
    int d3, d2, d1, d0;
    m  = int'(val) % 10000;
    d3 = m / 1000;
    d2 = (m / 100) % 10;
    d1 = (m / 10) % 10;
    d0 = m % 10;
    r[15:12] = d3[3:0];
    r[11:8]  = d2[3:0];
    r[7:4]   = d1[3:0];
    r[3:0]   = d0[3:0];
    return r;
  endfunction

  // Drive one input set, push its expected result, clock once, pop and compare.
  task automatic step(input logic [15:0] val, input logic vld, input logic rst, input string tag);
    exp_t e;
    exp_t got;
    logic nib_ok;
    bus.binary_in = val;
    bus.valid_i   = vld;
    rst_i         = rst;
    e.src = val;
    if (rst) begin
      e.bcd = 16'h0000;
      e.ovf = 1'b0;
      e.vld = 1'b0;
    end else begin
      e.bcd = ref_bcd(val);
      e.ovf = (val > 16'd9999);
      e.vld = vld;
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed %0d expected >0", tag, exp_q.size());
    end
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      checks++;
      assert (bus.bcd_o === got.bcd) else begin
        errors++;
        $error("FAIL %s bcd_o in=%0d observed %h expected %h", tag, got.src, bus.bcd_o, got.bcd);
      end
      checks++;
      assert (bus.ovf_o === got.ovf) else begin
        errors++;
        $error("FAIL %s ovf_o in=%0d observed %b expected %b", tag, got.src, bus.ovf_o, got.ovf);
      end
      checks++;
      assert (bus.valid_o === got.vld) else begin
        errors++;
        $error("FAIL %s valid_o in=%0d observed %b expected %b", tag, got.src, bus.valid_o, got.vld);
      end
    end
    nib_ok = (bus.bcd_o[15:12] <= 4'd9) && (bus.bcd_o[11:8] <= 4'd9) &&
             (bus.bcd_o[7:4] <= 4'd9) && (bus.bcd_o[3:0] <= 4'd9);
    checks++;
    assert (nib_ok === 1'b1) else begin
      errors++;
      $error("FAIL %s nibble_range observed %h expected all digits <= 9", tag, bus.bcd_o);
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_i         = 1'b1;
    bus.binary_in = 16'd0;
    bus.valid_i   = 1'b0;

    // Reset held two cycles with a live input that must be discarded.
    step(16'd1234, 1'b1, 1'b1, "reset0");
    step(16'd1234, 1'b1, 1'b1, "reset1");

    // Basic values.
    step(16'd256,  1'b1, 1'b0, "basic256");
    step(16'd1234, 1'b1, 1'b0, "basic1234");
    step(16'd4995, 1'b1, 1'b0, "basic4995");

    // Boundaries.
    step(16'd0,    1'b1, 1'b0, "bound0");
    step(16'd9,    1'b1, 1'b0, "bound9");
    step(16'd10,   1'b1, 1'b0, "bound10");
    step(16'd9999, 1'b1, 1'b0, "bound9999");

    // Overflow.
    step(16'd10000, 1'b1, 1'b0, "ovf10000");
    step(16'd65535, 1'b1, 1'b0, "ovf65535");
    step(16'd12345, 1'b1, 1'b0, "ovf12345");

    // Valid tracking, then reset mid-stream drops the in-flight value.
    step(16'd7,    1'b1, 1'b0, "pipe7");
    step(16'd8,    1'b0, 1'b0, "pipe8");
    step(16'd9,    1'b1, 1'b0, "pipe9");
    step(16'd4321, 1'b1, 1'b1, "midrst");
    step(16'd42,   1'b1, 1'b0, "postrst");

    // Exhaustive sweep.
    for (int v = 0; v < 65536; v++) begin
      step(16'(v), 1'b1, 1'b0, "sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
